// File: rtl/multi_sector_timer.sv
// multi_sector_timer: INDEX/SECTOR pulse trains and sector position for up to
// eight emulated ESDI drives. Each drive is configured and enabled through one
// AXI4-Lite CSR port.

// One timer channel: cycle counter, sector position and pulse generation.
module mst_channel #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [CNT_WIDTH-1:0] sector_len,
  input  logic [7:0]           num_sectors,
  input  logic [CNT_WIDTH-1:0] pulse_width,
  output logic [CNT_WIDTH-1:0] count,
  output logic [7:0]           sector,
  output logic                 index,
  output logic                 sector_pulse,
  output logic                 index_hit
);
  logic wrap, at_zero;

  // ">=" lets a shortened sector length take effect at once
  assign wrap      = count >= sector_len;
  assign at_zero   = count == '0;
  assign index_hit = en && at_zero && (sector == 8'd0);

  // Count, advance sector on wrap, raise the pulse at count 0 and drop it at
  // the pulse width or at the wrap, whichever is first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count        <= '0;
      sector       <= '0;
      index        <= 1'b0;
      sector_pulse <= 1'b0;
    end else if (!en) begin
      count        <= '0;
      sector       <= '0;
      index        <= 1'b0;
      sector_pulse <= 1'b0;
    end else begin
      count <= wrap ? '0 : count + CNT_WIDTH'(1);
      // num_sectors == 0 wraps after 255 through 8-bit arithmetic
      if (wrap)
        sector <= (sector == num_sectors - 8'd1) ? 8'd0 : sector + 8'd1;
      if (at_zero && pulse_width != '0) begin
        index        <= (sector == 8'd0);
        sector_pulse <= (sector != 8'd0);
      end else if (wrap || count == pulse_width) begin
        index        <= 1'b0;
        sector_pulse <= 1'b0;
      end
    end
  end
endmodule

module multi_sector_timer #(
  parameter int NUM_DRIVES    = 2,
  parameter int CNT_WIDTH     = 32,
  parameter int DEFAULT_PULSE = 500
) (
  input  logic                            csr_aclk,
  input  logic                            csr_aresetn,
  input  logic                            csr_awvalid,
  output logic                            csr_awready,
  input  logic [7:0]                      csr_awaddr,
  input  logic [2:0]                      csr_awprot,
  input  logic                            csr_wvalid,
  output logic                            csr_wready,
  input  logic [31:0]                     csr_wdata,
  input  logic [3:0]                      csr_wstrb,
  output logic                            csr_bvalid,
  input  logic                            csr_bready,
  output logic [1:0]                      csr_bresp,
  input  logic                            csr_arvalid,
  output logic                            csr_arready,
  input  logic [7:0]                      csr_araddr,
  input  logic [2:0]                      csr_arprot,
  output logic                            csr_rvalid,
  input  logic                            csr_rready,
  output logic [31:0]                     csr_rdata,
  output logic [1:0]                      csr_rresp,
  output logic [NUM_DRIVES-1:0]           esdi_index,
  output logic [NUM_DRIVES-1:0]           esdi_sector,
  output logic [NUM_DRIVES*CNT_WIDTH-1:0] cycle_count,
  output logic [NUM_DRIVES*8-1:0]         sector_number
);
  logic [NUM_DRIVES-1:0]                enable, index_seen, index_hit, seen_clr;
  logic [NUM_DRIVES-1:0][CNT_WIDTH-1:0] sector_len, pulse_width, count;
  logic [NUM_DRIVES-1:0][7:0]           num_sectors, sector;
  logic                                 aw_held, w_held, wr_fire;
  logic [7:0]                           aw_addr;
  logic [31:0]                          w_data, rd_val;
  logic [5:0]                           wr_idx;
  logic                                 unused_ok;

  assign csr_awready = !aw_held;
  assign csr_wready  = !w_held;
  assign csr_bresp   = 2'b00;
  assign csr_rresp   = 2'b00;
  assign csr_arready = !csr_rvalid || csr_rready;
  assign wr_fire     = aw_held && w_held && (!csr_bvalid || csr_bready);
  assign wr_idx      = aw_addr[7:2];
  assign seen_clr    = (wr_fire && wr_idx == 6'd1) ? w_data[NUM_DRIVES-1:0] : '0;
  // prot/strb are ignored and addresses are word-aligned
  assign unused_ok   = ^{csr_awprot, csr_arprot, csr_wstrb, aw_addr[1:0],
                         csr_araddr[1:0], w_data};

  // Write channel: hold AW and W independently, commit once both are held
  // and the B slot is free; the commit cycle issues the response.
  always_ff @(posedge csr_aclk or negedge csr_aresetn) begin
    if (!csr_aresetn) begin
      aw_held     <= 1'b0;
      w_held      <= 1'b0;
      aw_addr     <= '0;
      w_data      <= '0;
      csr_bvalid  <= 1'b0;
      enable      <= '0;
      sector_len  <= '0;
      num_sectors <= '0;
      for (int d = 0; d < NUM_DRIVES; d++) pulse_width[d] <= CNT_WIDTH'(DEFAULT_PULSE);
    end else begin
      if (csr_awvalid && !aw_held) begin
        aw_held <= 1'b1;
        aw_addr <= csr_awaddr;
      end
      if (csr_wvalid && !w_held) begin
        w_held <= 1'b1;
        w_data <= csr_wdata;
      end
      if (wr_fire) begin
        aw_held    <= 1'b0;
        w_held     <= 1'b0;
        csr_bvalid <= 1'b1;
        if (wr_idx == 6'd0) enable <= w_data[NUM_DRIVES-1:0];
        for (int d = 0; d < NUM_DRIVES; d++) begin
          if (wr_idx[5:2] == 4'(d + 1)) begin
            case (wr_idx[1:0])
              2'd0:    sector_len[d]  <= w_data[CNT_WIDTH-1:0];
              2'd1:    num_sectors[d] <= w_data[7:0];
              2'd2:    pulse_width[d] <= w_data[CNT_WIDTH-1:0];
              default: ;
            endcase
          end
        end
      end else if (csr_bready) begin
        csr_bvalid <= 1'b0;
      end
    end
  end

  // Sticky index-seen flags; a set in the same cycle as a clear wins.
  always_ff @(posedge csr_aclk or negedge csr_aresetn) begin
    if (!csr_aresetn) index_seen <= '0;
    else              index_seen <= (index_seen & ~seen_clr) | index_hit;
  end

  // Read decode; unmapped words read as zero.
  always_comb begin
    rd_val = '0;
    case (csr_araddr[7:2])
      6'd0:    rd_val = 32'(enable);
      6'd1:    rd_val = 32'(index_seen);
      6'd2:    rd_val = 32'(NUM_DRIVES);
      default: ;
    endcase
    for (int d = 0; d < NUM_DRIVES; d++) begin
      if (csr_araddr[7:4] == 4'(d + 1)) begin
        case (csr_araddr[3:2])
          2'd0:    rd_val = 32'(sector_len[d]);
          2'd1:    rd_val = 32'(num_sectors[d]);
          2'd2:    rd_val = 32'(pulse_width[d]);
          default: rd_val = 32'({enable[d], sector[d]});
        endcase
      end
    end
  end

  // Registered read response; data holds while the master stalls.
  always_ff @(posedge csr_aclk or negedge csr_aresetn) begin
    if (!csr_aresetn) begin
      csr_rvalid <= 1'b0;
      csr_rdata  <= '0;
    end else if (csr_arvalid && csr_arready) begin
      csr_rvalid <= 1'b1;
      csr_rdata  <= rd_val;
    end else if (csr_rready) begin
      csr_rvalid <= 1'b0;
    end
  end

  for (genvar d = 0; d < NUM_DRIVES; d++) begin : g_drv
    mst_channel #(.CNT_WIDTH(CNT_WIDTH)) u_chan (
      .clk          (csr_aclk),
      .rst_n        (csr_aresetn),
      .en           (enable[d]),
      .sector_len   (sector_len[d]),
      .num_sectors  (num_sectors[d]),
      .pulse_width  (pulse_width[d]),
      .count        (count[d]),
      .sector       (sector[d]),
      .index        (esdi_index[d]),
      .sector_pulse (esdi_sector[d]),
      .index_hit    (index_hit[d])
    );
  end

  assign cycle_count   = count;
  assign sector_number = sector;
endmodule

// File: tb/tb_multi_sector_timer.sv
// tb_multi_sector_timer: randomized checks of multi_sector_timer against a
// closed-form model of count, sector and pulses as a function of elapsed time.
module tb_multi_sector_timer;
  localparam int ND = 2;
  localparam int CW = 32;
  localparam int VW = 42;

  logic              csr_aclk = 0, csr_aresetn = 1;
  logic              csr_awvalid = 0, csr_awready;
  logic [7:0]        csr_awaddr = 0;
  logic [2:0]        csr_awprot = 0;
  logic              csr_wvalid = 0, csr_wready;
  logic [31:0]       csr_wdata = 0;
  logic [3:0]        csr_wstrb = 4'hF;
  logic              csr_bvalid, csr_bready = 1;
  logic [1:0]        csr_bresp;
  logic              csr_arvalid = 0, csr_arready;
  logic [7:0]        csr_araddr = 0;
  logic [2:0]        csr_arprot = 0;
  logic              csr_rvalid, csr_rready = 1;
  logic [31:0]       csr_rdata;
  logic [1:0]        csr_rresp;
  logic [ND-1:0]     esdi_index, esdi_sector;
  logic [ND*CW-1:0]  cycle_count;
  logic [ND*8-1:0]   sector_number;

  multi_sector_timer #(.NUM_DRIVES(ND), .CNT_WIDTH(CW), .DEFAULT_PULSE(500)) dut (
    .csr_aclk(csr_aclk), .csr_aresetn(csr_aresetn),
    .csr_awvalid(csr_awvalid), .csr_awready(csr_awready), .csr_awaddr(csr_awaddr), .csr_awprot(csr_awprot),
    .csr_wvalid(csr_wvalid), .csr_wready(csr_wready), .csr_wdata(csr_wdata), .csr_wstrb(csr_wstrb),
    .csr_bvalid(csr_bvalid), .csr_bready(csr_bready), .csr_bresp(csr_bresp),
    .csr_arvalid(csr_arvalid), .csr_arready(csr_arready), .csr_araddr(csr_araddr), .csr_arprot(csr_arprot),
    .csr_rvalid(csr_rvalid), .csr_rready(csr_rready), .csr_rdata(csr_rdata), .csr_rresp(csr_rresp),
    .esdi_index(esdi_index), .esdi_sector(esdi_sector),
    .cycle_count(cycle_count), .sector_number(sector_number)
  );

  always #5 csr_aclk = ~csr_aclk;

  int cyc = 0;
  always @(posedge csr_aclk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0, b_hs = 0, n_wr = 0;
  always @(negedge csr_aclk) if (csr_bvalid && csr_bready) b_hs++;

  // Reference model: drive d started its first count==0 cycle at m_t0[d].
  bit m_en[ND];
  int m_t0[ND], m_sl[ND], m_ns[ND], m_pw[ND];

  function automatic logic [ND*VW-1:0] exp_vec(input int t);
    logic [ND*VW-1:0] v;
    v = '0;
    for (int d = 0; d < ND; d++) begin
      longint k, per, c, n;
      int nsec, s;
      bit p;
      if (m_en[d]) begin
        k    = longint'(t - m_t0[d]);
        per  = longint'(m_sl[d]) + 1;
        c    = k % per;
        n    = k / per;
        nsec = (m_ns[d] == 0) ? 256 : m_ns[d];
        s    = int'(n % nsec);
        p    = (m_pw[d] != 0) && (c >= 1) && (c <= m_pw[d]);
        v[d*VW +: VW] = {p && (s == 0), p && (s != 0), 8'(s), 32'(c)};
      end
    end
    return v;
  endfunction

  function automatic logic [ND*VW-1:0] act_vec();
    logic [ND*VW-1:0] v;
    for (int d = 0; d < ND; d++)
      v[d*VW +: VW] = {esdi_index[d], esdi_sector[d], sector_number[d*8 +: 8], cycle_count[d*CW +: CW]};
    return v;
  endfunction

  // Tasks start and end on a falling edge; t_upd is the first cycle after the
  // register update edge.
  task automatic axi_write(input logic [7:0] a, input logic [31:0] d,
                           input int aw_dly, input int w_dly, output int t_upd);
    bit aw_done, w_done, aw_hs, w_hs;
    aw_done = 0; w_done = 0; t_upd = -1;
    csr_awaddr = a; csr_wdata = d;
    for (int n = 0; n < 64 && t_upd < 0; n++) begin
      csr_awvalid = !aw_done && n >= aw_dly;
      csr_wvalid  = !w_done && n >= w_dly;
      aw_hs = csr_awvalid && csr_awready;
      w_hs  = csr_wvalid && csr_wready;
      @(negedge csr_aclk);
      if (aw_hs) aw_done = 1;
      if (w_hs)  w_done = 1;
      if (csr_bvalid && aw_done && w_done) t_upd = cyc;
    end
    csr_awvalid = 0; csr_wvalid = 0;
    n_wr++;
    n_chk++;
    if (t_upd < 0 || csr_bresp !== 2'b00) begin
      n_fail++;
      $display("FAIL axi_write %h: resp=%b t=%0d, required OKAY response within 64 cycles", a, csr_bresp, t_upd);
    end
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d);
    bit got, hs;
    got = 0;
    csr_araddr = a; csr_arvalid = 1;
    for (int n = 0; n < 64 && !got; n++) begin
      hs = csr_arready;
      @(negedge csr_aclk);
      if (hs) begin csr_arvalid = 0; got = 1; end
    end
    csr_arvalid = 0;
    d = csr_rdata;
    n_chk++;
    if (!got || csr_rvalid !== 1'b1 || csr_rresp !== 2'b00) begin
      n_fail++;
      $display("FAIL axi_read %h: rvalid=%b resp=%b, required rvalid=1 OKAY one cycle after accept", a, csr_rvalid, csr_rresp);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d, e;
    @(negedge csr_aclk);
    csr_aresetn = 0;
    repeat (3) @(negedge csr_aclk);
    n_chk++;
    if ({esdi_index, esdi_sector, cycle_count, sector_number, csr_bvalid, csr_rvalid} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: idx=%b sec=%b cnt=%h sn=%h, required all 0", esdi_index, esdi_sector, cycle_count, sector_number);
    end
    csr_aresetn = 1;
    @(negedge csr_aclk);
    for (int a = 0; a < 256; a += 4) begin
      e = 0;
      if (a == 8) e = ND;
      for (int dd = 0; dd < ND; dd++) if (a == 16 * (dd + 1) + 8) e = 500;
      axi_read(8'(a), d);
      n_chk++;
      if (d !== e) begin
        n_fail++;
        $display("FAIL reset_reg %h: got %h, required %h", a, d, e);
      end
    end
  endtask

  task automatic test_axi();
    logic [31:0] r_sl[ND], r_ns[ND], r_pw[ND], d;
    int t, hs0;
    bit held;
    for (int dd = 0; dd < ND; dd++) begin
      r_sl[dd] = $urandom; r_ns[dd] = $urandom; r_pw[dd] = $urandom;
      axi_write(8'(16 * (dd + 1)),     r_sl[dd], 0, 3, t);  // AW before W
      axi_write(8'(16 * (dd + 1) + 4), r_ns[dd], 3, 0, t);  // W before AW
      axi_write(8'(16 * (dd + 1) + 8), r_pw[dd], 0, 0, t);
    end
    axi_write(8'h0C, $urandom, 0, 0, t);
    axi_write(8'h30, $urandom, 1, 0, t);
    axi_write(8'h34, $urandom, 0, 1, t);
    axi_write(8'hF8, $urandom, 0, 0, t);
    axi_write(8'h08, 32'h55, 0, 0, t);
    axi_write(8'h00, 32'hFFFF_FFFC, 0, 0, t);
    for (int dd = 0; dd < ND; dd++) begin
      axi_read(8'(16 * (dd + 1)), d);
      n_chk++; if (d !== r_sl[dd]) begin n_fail++; $display("FAIL rb_sl d%0d: got %h, required %h", dd, d, r_sl[dd]); end
      axi_read(8'(16 * (dd + 1) + 4), d);
      n_chk++; if (d !== (r_ns[dd] & 32'hFF)) begin n_fail++; $display("FAIL rb_ns d%0d: got %h, required %h", dd, d, r_ns[dd] & 32'hFF); end
      axi_read(8'(16 * (dd + 1) + 8), d);
      n_chk++; if (d !== r_pw[dd]) begin n_fail++; $display("FAIL rb_pw d%0d: got %h, required %h", dd, d, r_pw[dd]); end
      axi_read(8'(16 * (dd + 1) + 12), d);
      n_chk++; if (d !== 0) begin n_fail++; $display("FAIL rb_status d%0d: got %h, required 0", dd, d); end
    end
    axi_read(8'h0C, d); n_chk++; if (d !== 0) begin n_fail++; $display("FAIL unmapped_0c: got %h, required 0", d); end
    axi_read(8'h30, d); n_chk++; if (d !== 0) begin n_fail++; $display("FAIL unmapped_30: got %h, required 0", d); end
    axi_read(8'h08, d); n_chk++; if (d !== ND) begin n_fail++; $display("FAIL info_ro: got %h, required %h", d, ND); end
    axi_read(8'h00, d); n_chk++; if (d !== 0) begin n_fail++; $display("FAIL control_unused: got %h, required 0", d); end
    // B held while bready low
    csr_bready = 0;
    #1 hs0 = b_hs;
    axi_write(8'h18, 32'd10, 0, 0, t);
    held = 1;
    repeat (4) begin @(negedge csr_aclk); if (csr_bvalid !== 1'b1) held = 0; end
    n_chk++; if (!held) begin n_fail++; $display("FAIL bready_low: bvalid dropped, required held high"); end
    csr_bready = 1;
    repeat (3) @(negedge csr_aclk);
    #1;
    n_chk++;
    if (csr_bvalid !== 1'b0 || b_hs !== hs0 + 1) begin
      n_fail++;
      $display("FAIL bready_release: bvalid=%b handshakes=%0d, required 0 and %0d", csr_bvalid, b_hs - hs0, 1);
    end
    n_chk++;
    if (b_hs !== n_wr) begin n_fail++; $display("FAIL b_count: got %0d responses, required %0d", b_hs, n_wr); end
    // R held while rready low
    csr_rready = 0;
    axi_read(8'h10, d);
    held = (d === r_sl[0]);
    repeat (4) begin
      @(negedge csr_aclk);
      if (csr_rvalid !== 1'b1 || csr_rdata !== r_sl[0] || csr_arready !== 1'b0) held = 0;
    end
    n_chk++; if (!held) begin n_fail++; $display("FAIL rready_low: rvalid=%b rdata=%h, required 1 %h stable", csr_rvalid, csr_rdata, r_sl[0]); end
    csr_rready = 1;
    @(negedge csr_aclk);
    n_chk++; if (csr_rvalid !== 1'b0) begin n_fail++; $display("FAIL rready_release: rvalid=%b, required 0", csr_rvalid); end
  endtask

  task automatic test_single_drive();
    logic [ND*VW-1:0] ev, av;
    int t, hi_idx, hi_sec;
    axi_write(8'h10, 32'd99, 0, 0, t);
    axi_write(8'h14, 32'd4, 0, 0, t);
    axi_write(8'h18, 32'd10, 0, 0, t);
    axi_write(8'h00, 32'd1, 0, 0, t);
    m_en[0] = 1; m_t0[0] = t; m_sl[0] = 99; m_ns[0] = 4; m_pw[0] = 10;
    hi_idx = 0; hi_sec = 0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge csr_aclk);
      ev = exp_vec(cyc); av = act_vec();
      hi_idx += int'(esdi_index[0]); hi_sec += int'(esdi_sector[0]);
      n_chk++;
      if (av !== ev) begin n_fail++; $display("FAIL single_drive cyc=%0d: got %h, required %h", cyc, av, ev); end
    end
    n_chk++;
    if (hi_idx != 30 || hi_sec != 90) begin
      n_fail++;
      $display("FAIL single_pulse_totals: index %0d sector %0d cycles, required 30 and 90", hi_idx, hi_sec);
    end
  endtask

  task automatic test_index_seen();
    logic [31:0] d;
    int ti, t;
    ti = m_t0[0] + 400 * ((cyc - m_t0[0]) / 400 + 1);
    if (ti - 1 - cyc < 2) ti += 400;
    while (cyc < ti - 1) @(negedge csr_aclk);
    axi_write(8'h04, 32'h1, 0, 0, t);  // clear lands on the index-hit edge
    n_chk++; if (t !== ti + 1) begin n_fail++; $display("FAIL w1c_timing: update cycle %0d, required %0d", t, ti + 1); end
    axi_read(8'h04, d);
    n_chk++; if (d !== 32'h1) begin n_fail++; $display("FAIL seen_set_wins: got %h, required 1", d); end
    axi_write(8'h04, 32'h1, 0, 0, t);
    axi_read(8'h04, d);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL seen_clear: got %h, required 0", d); end
  endtask

  task automatic test_two_drives();
    logic [ND*VW-1:0] ev, av;
    logic [31:0] d;
    int t;
    axi_write(8'h00, 32'd0, 0, 0, t);
    m_en[0] = 0; m_en[1] = 0;
    m_sl[0] = $urandom_range(30, 80);  m_ns[0] = $urandom_range(1, 5); m_pw[0] = $urandom_range(1, m_sl[0]);
    m_sl[1] = $urandom_range(81, 150); m_ns[1] = $urandom_range(2, 6); m_pw[1] = $urandom_range(1, 60);
    for (int dd = 0; dd < ND; dd++) begin
      axi_write(8'(16 * (dd + 1)),     32'(m_sl[dd]), 0, 0, t);
      axi_write(8'(16 * (dd + 1) + 4), 32'(m_ns[dd]), 0, 0, t);
      axi_write(8'(16 * (dd + 1) + 8), 32'(m_pw[dd]), 0, 0, t);
    end
    axi_write(8'h04, 32'hFF, 0, 0, t);
    axi_write(8'h00, 32'h3, 0, 0, t);
    m_en[0] = 1; m_en[1] = 1; m_t0[0] = t; m_t0[1] = t;
    for (int i = 0; i < 1500; i++) begin
      @(negedge csr_aclk);
      if (i == 0) begin
        n_chk++;
        if (esdi_index !== 2'b11) begin n_fail++; $display("FAIL aligned_index: got %b, required 11", esdi_index); end
      end
      ev = exp_vec(cyc); av = act_vec();
      n_chk++;
      if (av !== ev) begin n_fail++; $display("FAIL two_drives cyc=%0d: got %h, required %h", cyc, av, ev); end
    end
    axi_read(8'h04, d);
    n_chk++; if (d !== 32'h3) begin n_fail++; $display("FAIL seen_both: got %h, required 3", d); end
    axi_write(8'h00, 32'd0, 0, 0, t);
    m_en[0] = 0; m_en[1] = 0;
    @(negedge csr_aclk);
    n_chk++; if (act_vec() !== '0) begin n_fail++; $display("FAIL disable: got %h, required 0", act_vec()); end
  endtask

  task automatic test_wrap_pulse();
    logic [ND*VW-1:0] ev, av;
    int t, prev;
    bit wrapped;
    axi_write(8'h10, 32'd20, 0, 0, t);
    axi_write(8'h14, 32'd0, 0, 0, t);
    axi_write(8'h18, 32'd50, 0, 0, t);
    axi_write(8'h00, 32'd1, 0, 0, t);
    m_en[0] = 1; m_t0[0] = t; m_sl[0] = 20; m_ns[0] = 0; m_pw[0] = 50;
    prev = 0; wrapped = 0;
    for (int i = 0; i < 256 * 21 + 40; i++) begin
      @(negedge csr_aclk);
      if (prev == 255 && sector_number[7:0] == 8'd0) wrapped = 1;
      prev = int'(sector_number[7:0]);
      ev = exp_vec(cyc); av = act_vec();
      n_chk++;
      if (av !== ev) begin n_fail++; $display("FAIL wrap_pulse cyc=%0d: got %h, required %h", cyc, av, ev); end
    end
    n_chk++; if (!wrapped) begin n_fail++; $display("FAIL sector_255_wrap: no 255->0 step, required one"); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int t;
    csr_rready = 0;
    axi_read(8'h18, d);
    csr_bready = 0;
    axi_write(8'h14, 32'd7, 0, 0, t);
    repeat (3) @(negedge csr_aclk);
    #3 csr_aresetn = 0;
    #1;
    n_chk++;
    if ({csr_bvalid, csr_rvalid, esdi_index, esdi_sector, cycle_count, sector_number} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: bvalid=%b rvalid=%b cnt=%h, required all 0", csr_bvalid, csr_rvalid, cycle_count);
    end
    @(negedge csr_aclk);
    csr_aresetn = 1; csr_bready = 1; csr_rready = 1;
    m_en[0] = 0; m_en[1] = 0;
    @(negedge csr_aclk);
    n_chk++; if (csr_bvalid !== 1'b0) begin n_fail++; $display("FAIL reset_mid_b: bvalid=%b, required 0", csr_bvalid); end
    axi_read(8'h18, d);
    n_chk++; if (d !== 32'd500) begin n_fail++; $display("FAIL reset_mid_pw: got %0d, required 500", d); end
    axi_read(8'h10, d);
    n_chk++; if (d !== 32'd0) begin n_fail++; $display("FAIL reset_mid_sl: got %0d, required 0", d); end
    axi_read(8'h00, d);
    n_chk++; if (d !== 32'd0) begin n_fail++; $display("FAIL reset_mid_ctrl: got %h, required 0", d); end
  endtask

  initial begin
    test_reset();
    test_axi();
    test_single_drive();
    test_index_seen();
    test_two_drives();
    test_wrap_pulse();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/multi_sector_timer.md
# multi_sector_timer

Parametrised, multi-drive successor to the single-drive ESDI sector timer. Generates independent INDEX/SECTOR pulse trains and sector position for up to eight emulated drives, each with its own sector length, sector count and pulse width, programmed over one AXI4-Lite CSR port. Adds synchronised start of several drives and a sticky per-drive index-seen flag for software revolution tracking. Sits between the CSR interconnect and the per-drive ESDI output/data-path logic.

## Interface
- NUM_DRIVES, 2, number of timer channels (1..8)
- CNT_WIDTH, 32, width of cycle counter, SECTOR_LENGTH and PULSE_WIDTH (8..32)
- DEFAULT_PULSE, 500, reset value of every PULSE_WIDTH register (~5 us)
- csr_aclk  in  1  sole clock
- csr_aresetn  in  1  reset, asynchronous and active-low
- csr_aw{valid,ready,addr[7:0],prot[2:0]}, csr_w{valid,ready,data[31:0],strb[3:0]}, csr_b{valid,ready,resp[1:0]}, csr_ar{valid,ready,addr[7:0],prot[2:0]}, csr_r{valid,ready,data[31:0],resp[1:0]}  AXI4-Lite slave; prot and strb ignored (full-word writes)
- esdi_index  out  NUM_DRIVES  per-drive index pulse
- esdi_sector  out  NUM_DRIVES  per-drive sector pulse
- cycle_count  out  NUM_DRIVES*CNT_WIDTH  per-drive count, drive d at [d*CNT_WIDTH +: CNT_WIDTH]
- sector_number  out  NUM_DRIVES*8  per-drive current sector, drive d at [d*8 +: 8]

## Operation
- Register map (addr[7:2] decode): 0x00 CONTROL, bit d = enable drive d, unused bits read 0; 0x04 INDEX_SEEN, bit d sticky, write-1-to-clear; 0x08 INFO, RO, [7:0]=NUM_DRIVES.
- Per drive d, base B=0x10*(d+1): B+0 SECTOR_LENGTH; B+4 NUM_SECTORS[7:0]; B+8 PULSE_WIDTH; B+C STATUS RO {[8]=enable, [7:0]=sector_number}. Register widths zero-extended on read, truncated on write.
- Unmapped or d>=NUM_DRIVES addresses: write discarded, read returns 0; resp always OKAY (00).
- Reset: all registers 0 except PULSE_WIDTH=DEFAULT_PULSE; all outputs 0; bvalid=rvalid=0.
- Per drive, when enabled: cycle_count increments each cycle; wraps to 0 when count >= SECTOR_LENGTH (>= so shrinking length mid-run wraps immediately); sector period = SECTOR_LENGTH+1 cycles.
- On wrap: sector_number increments, returning to 0 after NUM_SECTORS-1 (8-bit modulo; NUM_SECTORS=0 means 256 sectors).
- In cycle where count==0: assert esdi_index if sector_number==0 (also set INDEX_SEEN[d]), else esdi_sector. Both deassert when count==PULSE_WIDTH or on wrap, whichever first. PULSE_WIDTH=0: no pulse, INDEX_SEEN still sets.
- Disabled drive: count, sector_number, pulses forced to 0 next cycle. Drives enabled by the same CONTROL write start in the same cycle, hence phase-aligned.
- INDEX_SEEN set and W1C clear same cycle: set wins.

## Timing
- Write: AW and W accepted independently (awready=!aw_held, wready=!w_held); register updates and bvalid rises one cycle after both held and (!bvalid||bready). Timer uses new value the following cycle.
- Enable write: first count==0 cycle = cycle after register update; esdi_index high one cycle later, stays high PULSE_WIDTH cycles.
- Read: arready = !rvalid || rready; rdata/rvalid registered, one-cycle latency, back-to-back reads at full rate; rdata stable while rvalid && !rready.
- Reset assertion mid-operation: all state to reset values immediately, no pending B/R response survives.

## Test plan
- Reset then read all registers -> PULSE_WIDTH regs read 500, all else 0; outputs 0.
- Drive 0: SECTOR_LENGTH=99, NUM_SECTORS=4, PULSE_WIDTH=10, enable -> index high 10 cycles every 400, sector pulses 10 cycles at 100/200/300, sector_number 0..3.
- Both drives configured differently, enabled in one write -> index rises same cycle on both; thereafter independent periods.
- PULSE_WIDTH=50, SECTOR_LENGTH=20 -> pulse drops on wrap, low one cycle, re-asserts; NUM_SECTORS=0 -> sector_number reaches 255 then 0.
- INDEX_SEEN W1C issued on index cycle -> bit remains 1; clear in other cycle -> reads 0.
- AW before W, W before AW, bready held low, rready held low, unmapped address -> single OKAY per transaction, correct data, no lost/duplicated responses.
